hdlc_rx_deframer: RTL and testbench
===================================

// Module: hdlc_rx_deframer
// PURPOSE
// Serial front end of the HDLC receive path; sits between the Rx pin and the Rx buffer/FCS/status logic.
// Detects flags and aborts, removes inserted zeros and assembles LSB-first bytes.
// Emits per-byte strobes plus frame start/stop/error/abort pulses to the downstream buffer and FCS checker.
// PARAMETERS
// MIN_FRAME_BYTES  4    frames closing with fewer bytes (incl. 2 FCS bytes) flag Rx_FrameError
// MAX_FRAME_BYTES  130  byte counter saturates here; Rx_Overflow pulses once when a byte beyond this arrives
// PORTS
// Clk              in   1  system clock; all state updates on posedge
// Rst              in   1  asynchronous, active-low reset
// Rx               in   1  serial line, one bit per clock
// RxEN             in   1  receiver enable; low = synchronous flush to HUNT
// Rx_FlagDetect    out  1  1-cycle pulse: 01111110 seen
// Rx_AbortDetect   out  1  1-cycle pulse: 0 followed by seven 1s seen
// Rx_ValidFrame    out  1  high while inside a frame (first data bit .. closing flag/abort)
// Rx_NewByte       out  1  1-cycle pulse: Rx_Data holds a new de-stuffed byte
// Rx_Data          out  8  last assembled byte, held until next Rx_NewByte
// Rx_StartFCS      out  1  1-cycle pulse with Rx_ValidFrame rising
// Rx_StopFCS       out  1  1-cycle pulse on closing flag of a frame
// Rx_FrameError    out  1  1-cycle pulse with Rx_StopFCS if misaligned or too short
// Rx_Overflow      out  1  1-cycle pulse, see MAX_FRAME_BYTES
// Rx_EoF           out  1  1-cycle pulse the cycle after Rx_ValidFrame falls (close or abort)
// BEHAVIOUR
// - Reset/RxEN=0: all outputs 0, Rx_Data=8'h00, window=8'hFF, ones-count/bit-count/byte-count=0, state HUNT.
// - Edge k: Rx -> RxD. Edge k+1: RxD shifts into 8-bit window (time-ordered). Window compare is comb.
//   Edge k+2: Rx_FlagDetect/Rx_AbortDetect register the compare. Latency = 2 clocks after the last pattern bit.
// - Abort match = window time-order 0,1,1,1,1,1,1,1; fires in or out of frame; fires once per run of 1s.
// - Data path consumes the bit leaving the window (8-clock delay) so flag/abort bits never reach the assembler.
//   A flag/abort hit discards the window contents for data purposes.
// - Zero removal: a 0 exiting after five consecutive exiting 1s is dropped (not counted); the ones-counter then clears.
// - Assembly: LSB first, 3-bit counter; 8th kept bit -> Rx_NewByte pulse, Rx_Data updated same cycle.
// - FSM: HUNT -(flag)-> OPEN; OPEN -(flag)-> OPEN (shared/back-to-back flags).
//   OPEN -(first kept data bit exits)-> FRAME: Rx_ValidFrame=1, Rx_StartFCS pulse.
//   FRAME -(flag)-> OPEN: Rx_ValidFrame=0, Rx_StopFCS pulse, Rx_FrameError if bitcnt!=0 or bytes<MIN_FRAME_BYTES.
//   FRAME -(abort)-> HUNT: Rx_ValidFrame=0, no StopFCS. Any state -(abort)-> HUNT.
//   Rx_EoF pulses one cycle after either falling edge of Rx_ValidFrame.
// - Byte completing at window exit in the same cycle a flag is hit: byte is delivered (NewByte) before close.
// - Byte counter 8-bit, saturates at MAX_FRAME_BYTES; Rx_NewByte still pulses on overflow bytes.
// - Idle (continuous 1s) with no preceding 0: no Flag/Abort pulses, FSM stays HUNT.
// - RxEN falling mid-frame: flush on next edge, Rx_ValidFrame=0, no StopFCS/EoF/FrameError.
// - Async reset mid-frame: immediate clear to reset values; no pulses on release.
// TESTING
// 1. Flag, bytes A5,FF,12,34, flag (FF sent with stuffed 0) -> 4 NewByte with A5,FF,12,34; StartFCS once;
//    StopFCS once; FrameError=0; EoF 1 cycle after ValidFrame falls.
// 2. Flag, then sample 01111110 ending at cycle t -> Rx_FlagDetect high exactly at t+2 for one cycle.
// 3. Flag, bytes 11,22, then 0 + 7 ones -> AbortDetect at t+2; ValidFrame drops, no StopFCS, EoF next cycle.
// 4. Flag, bytes 11,22,33,44 + 3 extra bits, flag -> StopFCS with FrameError=1; same with 2 bytes -> FrameError=1.
// 5. 32 ones from reset, RxEN=1 -> no FlagDetect, no AbortDetect, ValidFrame=0 throughout.
// 6. 131-byte frame -> Overflow pulses once on byte 131; then RxEN=0 mid-frame -> all outputs 0 next cycle, no EoF.

Source files
------------

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero removal and LSB-first byte assembly.
// Emits per-byte strobes and frame start/stop/error/abort/overflow/end pulses.
module hdlc_rx_deframer #(
    parameter int unsigned MIN_FRAME_BYTES = 4,
    parameter int unsigned MAX_FRAME_BYTES = 130
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       rx_en_i,
    output logic       rx_flag_detect_o,
    output logic       rx_abort_detect_o,
    output logic       rx_valid_frame_o,
    output logic       rx_new_byte_o,
    output logic [7:0] rx_data_o,
    output logic       rx_start_fcs_o,
    output logic       rx_stop_fcs_o,
    output logic       rx_frame_error_o,
    output logic       rx_overflow_o,
    output logic       rx_eof_o
);

    localparam int unsigned DW  = 8;
    localparam int unsigned BCW = 8;

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_OPEN  = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           rx_d_q, rx_d_d;
    logic [DW-1:0]  win_q, win_d;
    logic [DW-1:0]  vld_q, vld_d;
    logic [2:0]     ones_q, ones_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]  sh_q, sh_d;
    logic [DW-1:0]  data_q, data_d;
    logic           ovf_done_q, ovf_done_d;
    logic           valid_q, valid_d;
    logic           flag_q, flag_d;
    logic           abort_q, abort_d;
    logic           new_byte_q, new_byte_d;
    logic           start_q, start_d;
    logic           stop_q, stop_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;
    logic           fall_q, fall_d;
    logic           eof_q, eof_d;

    logic flag_hit;
    logic abort_hit;
    logic keep;

    // Window is time-ordered: bit 7 is the oldest sample, bit 0 the newest.
    assign flag_hit  = (win_q == 8'h7E);
    assign abort_hit = (win_q == 8'h7F);

    always_comb begin
        state_d    = state_q;
        rx_d_d     = rx_i;
        win_d      = {win_q[DW-2:0], rx_d_q};
        vld_d      = {vld_q[DW-2:0], 1'b1};
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sh_d       = sh_q;
        data_d     = data_q;
        ovf_done_d = ovf_done_q;
        valid_d    = valid_q;
        flag_d     = flag_hit;
        abort_d    = abort_hit;
        new_byte_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        err_d      = 1'b0;
        ovf_d      = 1'b0;
        fall_d     = 1'b0;
        eof_d      = fall_q;
        keep       = 1'b0;

        if (flag_hit || abort_hit) begin
            // Pattern bits still in the window must never reach the assembler.
            vld_d      = 8'h01;
            ones_d     = 3'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            ovf_done_d = 1'b0;
            if (state_q == ST_FRAME) begin
                valid_d = 1'b0;
                fall_d  = 1'b1;
                if (flag_hit) begin
                    stop_d = 1'b1;
                    err_d  = (bit_cnt_q != 3'd0) || (byte_cnt_q < BCW'(MIN_FRAME_BYTES));
                end
            end
            state_d = abort_hit ? ST_HUNT : ST_OPEN;
        end else if (vld_q[DW-1]) begin
            if (win_q[DW-1]) begin
                ones_d = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
                keep   = 1'b1;
            end else begin
                ones_d = 3'd0;
                keep   = (ones_q != 3'd5);
            end
            if (keep && (state_q != ST_HUNT)) begin
                if (state_q == ST_OPEN) begin
                    state_d = ST_FRAME;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                end
                sh_d      = {win_q[DW-1], sh_q[DW-1:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    new_byte_d = 1'b1;
                    data_d     = {win_q[DW-1], sh_q[DW-1:1]};
                    if (byte_cnt_q == BCW'(MAX_FRAME_BYTES)) begin
                        ovf_d      = ~ovf_done_q;
                        ovf_done_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
        end

        // Receiver disabled: synchronous flush to the reset state.
        if (!rx_en_i) begin
            state_d    = ST_HUNT;
            rx_d_d     = 1'b1;
            win_d      = 8'hFF;
            vld_d      = '0;
            ones_d     = 3'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            sh_d       = '0;
            data_d     = '0;
            ovf_done_d = 1'b0;
            valid_d    = 1'b0;
            flag_d     = 1'b0;
            abort_d    = 1'b0;
            new_byte_d = 1'b0;
            start_d    = 1'b0;
            stop_d     = 1'b0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
            fall_d     = 1'b0;
            eof_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            rx_d_q     <= 1'b1;
            win_q      <= 8'hFF;
            vld_q      <= '0;
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            sh_q       <= '0;
            data_q     <= '0;
            ovf_done_q <= 1'b0;
            valid_q    <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            new_byte_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            fall_q     <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_d_q     <= rx_d_d;
            win_q      <= win_d;
            vld_q      <= vld_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
            data_q     <= data_d;
            ovf_done_q <= ovf_done_d;
            valid_q    <= valid_d;
            flag_q     <= flag_d;
            abort_q    <= abort_d;
            new_byte_q <= new_byte_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            fall_q     <= fall_d;
            eof_q      <= eof_d;
        end
    end

    assign rx_flag_detect_o  = flag_q;
    assign rx_abort_detect_o = abort_q;
    assign rx_valid_frame_o  = valid_q;
    assign rx_new_byte_o     = new_byte_q;
    assign rx_data_o         = data_q;
    assign rx_start_fcs_o    = start_q;
    assign rx_stop_fcs_o     = stop_q;
    assign rx_frame_error_o  = err_q;
    assign rx_overflow_o     = ovf_q;
    assign rx_eof_o          = eof_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: the bit driver queues expected events with their
// cycle numbers; a monitor pops and compares every pulse the deframer presents.
module tb_hdlc_rx_deframer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_en_i = 1'b1;
    logic       rx_flag_detect_o, rx_abort_detect_o, rx_valid_frame_o, rx_new_byte_o;
    logic [7:0] rx_data_o;
    logic       rx_start_fcs_o, rx_stop_fcs_o, rx_frame_error_o, rx_overflow_o, rx_eof_o;

    hdlc_rx_deframer #(.MIN_FRAME_BYTES(4), .MAX_FRAME_BYTES(130)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_en_i(rx_en_i),
        .rx_flag_detect_o(rx_flag_detect_o), .rx_abort_detect_o(rx_abort_detect_o),
        .rx_valid_frame_o(rx_valid_frame_o), .rx_new_byte_o(rx_new_byte_o),
        .rx_data_o(rx_data_o), .rx_start_fcs_o(rx_start_fcs_o), .rx_stop_fcs_o(rx_stop_fcs_o),
        .rx_frame_error_o(rx_frame_error_o), .rx_overflow_o(rx_overflow_o), .rx_eof_o(rx_eof_o)
    );

    always #5 clk = ~clk;

    localparam int EV_FLAG = 0, EV_ABORT = 1, EV_STOP = 2, EV_VFALL = 3, EV_START = 4;
    localparam int EV_VRISE = 5, EV_BYTE = 6, EV_OVF = 7, EV_EOF = 8, EV_ERRX = 9;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  edge_cnt = 0;
    int  last_edge = 0;
    int  data_edge = 0;
    int  ones_tb = 0;
    bit  in_frame = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic push(input int k, input int d, input int c);
        ev_t e;
        e.kind = k; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input int k, input int d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%0h cycle=%0d, required none", k, d, edge_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d || e.cyc != edge_cnt) begin
                n_bad++;
                $display("FAIL event: got kind=%0d data=%0h cycle=%0d, required kind=%0d data=%0h cycle=%0d",
                         k, d, edge_cnt, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: fixed per-cycle order matches the order the driver queues same-cycle events.
    initial begin
        bit vf_prev;
        vf_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_flag_detect_o)  chk(EV_FLAG, 0);
            if (rx_abort_detect_o) chk(EV_ABORT, 0);
            if (rx_stop_fcs_o)     chk(EV_STOP, int'(rx_frame_error_o));
            if (rx_frame_error_o && !rx_stop_fcs_o) chk(EV_ERRX, 1);
            if (vf_prev && !rx_valid_frame_o) chk(EV_VFALL, 0);
            if (rx_start_fcs_o)    chk(EV_START, 0);
            if (!vf_prev && rx_valid_frame_o) chk(EV_VRISE, 0);
            if (rx_new_byte_o)     chk(EV_BYTE, int'(rx_data_o));
            if (rx_overflow_o)     chk(EV_OVF, 0);
            if (rx_eof_o)          chk(EV_EOF, 0);
            vf_prev = rx_valid_frame_o;
        end
    end

    task automatic check_idle(input string name);
        logic [16:0] obs;
        obs = {rx_flag_detect_o, rx_abort_detect_o, rx_valid_frame_o, rx_new_byte_o, rx_start_fcs_o,
               rx_stop_fcs_o, rx_frame_error_o, rx_overflow_o, rx_eof_o, rx_data_o};
        n_cmp++;
        if (obs !== 17'd0) begin
            n_bad++;
            $display("FAIL %s: outputs=%h, required 0", name, obs);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        @(posedge clk);
        #1;
        last_edge = edge_cnt;
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b);
        data_edge = last_edge;
        if (!in_frame) begin
            push(EV_START, 0, last_edge + 9);
            push(EV_VRISE, 0, last_edge + 9);
            in_frame = 1'b1;
        end
        if (b) begin
            ones_tb++;
            if (ones_tb == 5) begin
                send_bit(1'b0);
                ones_tb = 0;
            end
        end else begin
            ones_tb = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
        push(EV_BYTE, int'(b), data_edge + 9);
    endtask

    task automatic send_pattern(input logic [7:0] pat);
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        ones_tb = 0;
    endtask

    task automatic send_flag(input int err);
        send_pattern(8'b0111_1110);
        push(EV_FLAG, 0, last_edge + 2);
        if (in_frame) begin
            push(EV_STOP, err, last_edge + 2);
            push(EV_VFALL, 0, last_edge + 2);
            push(EV_EOF, 0, last_edge + 3);
            in_frame = 1'b0;
        end
    endtask

    task automatic send_abort();
        send_pattern(8'b0111_1111);
        push(EV_ABORT, 0, last_edge + 2);
        if (in_frame) begin
            push(EV_VFALL, 0, last_edge + 2);
            push(EV_EOF, 0, last_edge + 3);
            in_frame = 1'b0;
        end
    endtask

    task automatic drain(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        rx_i = 1'b1;
        rx_en_i = 1'b1;
        in_frame = 1'b0;
        ones_tb = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        ev_t e;
        do_reset();

        // Idle ones from reset: no flag, no abort, no frame.
        drain(1'b1, 32);
        check_idle("idle_ones");

        // Good frame with a stuffed zero inside FF.
        do_reset();
        send_flag(0);
        send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h12); send_byte(8'h34);
        send_flag(0);
        drain(1'b0, 4);

        // Back-to-back flags: exact flag latency.
        do_reset();
        send_flag(0);
        send_flag(0);
        drain(1'b0, 4);

        // Abort inside a frame.
        do_reset();
        send_flag(0);
        send_byte(8'h11); send_byte(8'h22);
        send_abort();
        drain(1'b1, 4);

        // Misaligned frame, then a short frame sharing the closing flag.
        do_reset();
        send_flag(0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
        send_flag(1);
        send_byte(8'h55); send_byte(8'h66);
        send_flag(1);
        drain(1'b0, 4);

        // Overflow on byte 131 only, then disable mid-frame.
        do_reset();
        send_flag(0);
        for (int i = 0; i < 132; i++) begin
            send_byte(8'(i * 37 + 5));
            if (i == 130) push(EV_OVF, 0, data_edge + 9);
        end
        drain(1'b0, 9);
        rx_en_i = 1'b0;
        push(EV_VFALL, 0, edge_cnt + 1);
        @(posedge clk);
        #1;
        check_idle("flush_next_cycle");
        repeat (5) @(posedge clk);
        #1;
        check_idle("flush_hold");
        rx_en_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got none, required kind=%0d data=%0h cycle=%0d", e.kind, e.data, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
